// File: rtl/cdb_arbiter.sv
// Common data bus producer: per-FU result FIFOs drained one per cycle
// by a round-robin arbiter into a registered {valid, tag, value} bus.
module cdb_arbiter #(
   parameter int NUM_FU    = 5,
   parameter int TAG_W     = 5,
   parameter int DATA_W    = 32,
   parameter int BUF_DEPTH = 2,
   localparam int FU_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_FU-1:0]        fu_valid,
   input  logic [NUM_FU*TAG_W-1:0]  fu_tag,
   input  logic [NUM_FU*DATA_W-1:0] fu_value,
   output logic [NUM_FU-1:0]        fu_ready,
   input  logic                     flush,
   output logic                     cdb_valid,
   output logic [TAG_W-1:0]         cdb_tag,
   output logic [DATA_W-1:0]        cdb_value,
   output logic [FU_W-1:0]          cdb_fu,
   output logic                     drop_err
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   logic [TAG_W-1:0]  mem_tag   [NUM_FU][BUF_DEPTH];
   logic [DATA_W-1:0] mem_value [NUM_FU][BUF_DEPTH];
   logic [PTR_W-1:0]  rd_ptr    [NUM_FU];
   logic [PTR_W-1:0]  wr_ptr    [NUM_FU];
   logic [CNT_W-1:0]  count     [NUM_FU];

   logic [NUM_FU-1:0] ready;
   logic [NUM_FU-1:0] nonempty;
   logic [NUM_FU-1:0] push;
   logic [NUM_FU-1:0] pop;
   logic [NUM_FU-1:0] zero_hit;
   logic [FU_W-1:0]   rr_ptr;
   logic [FU_W-1:0]   winner;
   logic              found;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [FU_W-1:0] fu_inc(input logic [FU_W-1:0] f);
      return (f == FU_W'(NUM_FU - 1)) ? '0 : f + 1'b1;
   endfunction

   // Ready looks only at registered occupancy, never at this cycle's pop.
   always_comb begin
      ready    = '0;
      nonempty = '0;
      push     = '0;
      zero_hit = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         ready[i]    = (count[i] != CNT_W'(BUF_DEPTH));
         nonempty[i] = (count[i] != '0);
         if (fu_valid[i] && ready[i]) begin
            if (fu_tag[i*TAG_W +: TAG_W] == '0)
               zero_hit[i] = 1'b1;
            else if (!flush)
               push[i] = 1'b1;
         end
      end
   end

   assign fu_ready = ready;

   always_comb begin
      logic [FU_W:0] idx;
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         idx = {1'b0, rr_ptr} + (FU_W+1)'(k);
         if (idx >= (FU_W+1)'(NUM_FU))
            idx = idx - (FU_W+1)'(NUM_FU);
         if (!found && nonempty[idx[FU_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[FU_W-1:0];
         end
      end
   end

   always_comb begin
      pop = '0;
      if (found && !flush)
         pop[winner] = 1'b1;
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_FU; i++) begin
         if (push[i]) begin
            mem_tag[i][wr_ptr[i]]   <= fu_tag[i*TAG_W +: TAG_W];
            mem_value[i][wr_ptr[i]] <= fu_value[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_FU; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         rr_ptr    <= '0;
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_value <= '0;
         cdb_fu    <= '0;
         drop_err  <= 1'b0;
      end else begin
         if (|zero_hit)
            drop_err <= 1'b1;
         if (flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
               rd_ptr[i] <= '0;
               wr_ptr[i] <= '0;
               count[i]  <= '0;
            end
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_fu    <= '0;
         end else begin
            for (int i = 0; i < NUM_FU; i++) begin
               if (push[i])
                  wr_ptr[i] <= ptr_inc(wr_ptr[i]);
               if (pop[i])
                  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
               if (push[i] && !pop[i])
                  count[i] <= count[i] + 1'b1;
               else if (pop[i] && !push[i])
                  count[i] <= count[i] - 1'b1;
            end
            if (found) begin
               cdb_valid <= 1'b1;
               cdb_tag   <= mem_tag[winner][rd_ptr[winner]];
               cdb_value <= mem_value[winner][rd_ptr[winner]];
               cdb_fu    <= winner;
               rr_ptr    <= fu_inc(winner);
            end else begin
               cdb_valid <= 1'b0;
               cdb_tag   <= '0;
               cdb_value <= '0;
               cdb_fu    <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vector bench for cdb_arbiter: table of per-cycle stimulus with
// hand-computed bus outputs, plus an asynchronous mid-stream reset sequence.
module tb_cdb_arbiter;

   logic         clock = 1'b0;
   logic         reset;
   logic [4:0]   fu_valid;
   logic [24:0]  fu_tag;
   logic [159:0] fu_value;
   logic [4:0]   fu_ready;
   logic         flush;
   logic         cdb_valid;
   logic [4:0]   cdb_tag;
   logic [31:0]  cdb_value;
   logic [2:0]   cdb_fu;
   logic         drop_err;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   cdb_arbiter dut (
      .clock     (clock),
      .reset     (reset),
      .fu_valid  (fu_valid),
      .fu_tag    (fu_tag),
      .fu_value  (fu_value),
      .fu_ready  (fu_ready),
      .flush     (flush),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_value (cdb_value),
      .cdb_fu    (cdb_fu),
      .drop_err  (drop_err)
   );

   typedef struct {
      logic [4:0]  v;
      logic [24:0] tags;
      logic [31:0] base;
      logic        fl;
      logic        cv;
      logic [4:0]  ct;
      logic [31:0] cval;
      logic [2:0]  cfu;
      logic [4:0]  rdy;
      logic        derr;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [24:0] tg(input int t0, t1, t2, t3, t4);
      return {5'(t4), 5'(t3), 5'(t2), 5'(t1), 5'(t0)};
   endfunction

   task automatic add(input logic [4:0] v, input logic [24:0] tags,
                      input logic [31:0] base, input logic fl,
                      input logic cv, input int ct, input logic [31:0] cval,
                      input int cfu, input logic [4:0] rdy, input logic derr);
      vec_t e;
      e.v = v; e.tags = tags; e.base = base; e.fl = fl;
      e.cv = cv; e.ct = 5'(ct); e.cval = cval; e.cfu = 3'(cfu);
      e.rdy = rdy; e.derr = derr;
      vecs.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] v, input logic [24:0] tags,
                        input logic [31:0] base, input logic fl);
      fu_valid = v;
      fu_tag   = tags;
      flush    = fl;
      for (int i = 0; i < 5; i++)
         fu_value[i*32 +: 32] = base + 32'(i);
   endtask

   task automatic chk_out(input string n, input logic cv, input int ct,
                          input logic [31:0] cval, input int cfu);
      chk({n, ".valid"}, 32'(cdb_valid), 32'(cv));
      chk({n, ".tag"},   32'(cdb_tag),   32'(ct));
      chk({n, ".value"}, cdb_value,      cval);
      chk({n, ".fu"},    32'(cdb_fu),    32'(cfu));
   endtask

   localparam logic [4:0] N = 5'b00000;
   localparam logic [4:0] A = 5'b11111;

   initial begin
      // single result from FU2
      add(5'b00100, tg(0,0,7,0,0), 32'hDEADBEED, 0, 0,0,0,0, A, 0);
      add(N, '0, 0, 0, 1,7,32'hDEADBEEF,2, A, 0);
      add(N, '0, 0, 0, 0,0,0,0, A, 0);
      // steer rr_ptr back to 0 through FU4
      add(5'b10000, tg(0,0,0,0,1), 32'h10, 0, 0,0,0,0, A, 0);
      add(N, '0, 0, 0, 1,1,32'h14,4, A, 0);
      // contention FU0/1/4 from rr_ptr 0
      add(5'b10011, tg(3,4,0,0,5), 32'h100, 0, 0,0,0,0, A, 0);
      add(N, '0, 0, 0, 1,3,32'h100,0, A, 0);
      add(N, '0, 0, 0, 1,4,32'h101,1, A, 0);
      add(N, '0, 0, 0, 1,5,32'h104,4, A, 0);
      add(N, '0, 0, 0, 0,0,0,0, A, 0);
      // zero tag
      add(5'b00001, tg(0,0,0,0,0), 32'h0, 0, 0,0,0,0, A, 1);
      add(N, '0, 0, 0, 0,0,0,0, A, 1);
      // backpressure: FU1 holds 10/11/12 against ready, FU0 streams
      add(5'b00011, tg(20,10,0,0,0), 32'h200, 0, 0,0,0,0, A, 1);
      add(5'b00011, tg(21,11,0,0,0), 32'h200, 0, 1,20,32'h200,0, 5'h1d, 1);
      add(5'b00011, tg(22,12,0,0,0), 32'h200, 0, 1,10,32'h201,1, 5'h1e, 1);
      add(5'b00011, tg(23,12,0,0,0), 32'h200, 0, 1,21,32'h200,0, 5'h1d, 1);
      add(5'b00001, tg(23,0,0,0,0),  32'h200, 0, 1,11,32'h201,1, 5'h1e, 1);
      add(N, '0, 0, 0, 1,22,32'h200,0, A, 1);
      add(N, '0, 0, 0, 1,12,32'h201,1, A, 1);
      add(N, '0, 0, 0, 1,23,32'h200,0, A, 1);
      add(N, '0, 0, 0, 0,0,0,0, A, 1);
      // flush with 6 and 9 buffered, 8 offered in the flush cycle
      add(5'b01110, tg(0,2,9,6,0), 32'h300, 0, 0,0,0,0, A, 1);
      add(N, '0, 0, 0, 1,2,32'h301,1, A, 1);
      add(5'b01000, tg(0,0,0,8,0), 32'h300, 1, 0,0,0,0, A, 1);
      add(N, '0, 0, 0, 0,0,0,0, A, 1);
      add(5'b01000, tg(0,0,0,13,0), 32'h400, 0, 0,0,0,0, A, 1);
      add(N, '0, 0, 0, 1,13,32'h403,3, A, 1);
      add(N, '0, 0, 0, 0,0,0,0, A, 1);

      reset = 1'b1;
      drive(N, '0, 0, 0);
      #12;
      chk_out("reset", 0, 0, 0, 0);
      chk("reset.ready", 32'(fu_ready), 32'(A));
      chk("reset.drop", 32'(drop_err), 0);
      reset = 1'b0;

      foreach (vecs[n]) begin
         string nm;
         nm = $sformatf("v%0d", n + 1);
         drive(vecs[n].v, vecs[n].tags, vecs[n].base, vecs[n].fl);
         @(posedge clock);
         #1;
         chk_out(nm, vecs[n].cv, int'(vecs[n].ct), vecs[n].cval,
                 int'(vecs[n].cfu));
         chk({nm, ".ready"}, 32'(fu_ready), 32'(vecs[n].rdy));
         chk({nm, ".drop"},  32'(drop_err), 32'(vecs[n].derr));
      end

      // mid-stream reset: five pushed, one broadcast, four pending
      drive(A, tg(14,15,16,17,18), 32'h500, 0);
      @(posedge clock);
      #1;
      chk_out("mr.push", 0, 0, 0, 0);
      drive(N, '0, 0, 0);
      @(posedge clock);
      #1;
      chk_out("mr.bcast", 1, 18, 32'h504, 4);
      chk("mr.ready", 32'(fu_ready), 32'(A));
      #2;
      reset = 1'b1;
      #1;
      chk_out("mr.async", 0, 0, 0, 0);
      chk("mr.drop", 32'(drop_err), 0);
      @(negedge clock);
      reset = 1'b0;
      chk("mr.ready_rel", 32'(fu_ready), 32'(A));
      for (int c = 0; c < 6; c++) begin
         @(posedge clock);
         #1;
         chk_out($sformatf("mr.idle%0d", c), 0, 0, 0, 0);
      end

      // rr_ptr restarted at 0: FU0 beats FU3
      drive(5'b01001, tg(19,0,0,21,0), 32'h600, 0);
      @(posedge clock);
      #1;
      drive(N, '0, 0, 0);
      @(posedge clock);
      #1;
      chk_out("post.first", 1, 19, 32'h600, 0);
      @(posedge clock);
      #1;
      chk_out("post.second", 1, 21, 32'h603, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
